// File: rtl/blur_pkg.sv
// Shared constants and state encoding for the 3x3 binomial blur engine.
package blur_pkg;

   localparam int TAP_COUNT    = 9;
   localparam int KERNEL_SHIFT = 4;
   localparam int ROUND_BIAS   = 8;

   localparam logic [2:0] KERNEL_WEIGHT [TAP_COUNT] = '{
      3'd1, 3'd2, 3'd1,
      3'd2, 3'd4, 3'd2,
      3'd1, 3'd2, 3'd1
   };

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } blur_state_t;

endpackage

// File: rtl/blur_tap_addr_gen.sv
// Combinational tap generator: maps centre (cx, cy) and tap index k to a
// clamped source address, kernel weight, out-of-image flag and last-tap flag.
module blur_tap_addr_gen
   import blur_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int HEIGHT = 64
) (
   input  logic [$clog2(WIDTH)-1:0]        cx,
   input  logic [$clog2(HEIGHT)-1:0]       cy,
   input  logic [3:0]                      k,
   output logic [$clog2(WIDTH*HEIGHT)-1:0] addr,
   output logic [2:0]                      weight,
   output logic                            oob,
   output logic                            last
);

   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   localparam int AW = $clog2(WIDTH*HEIGHT);

   logic [1:0]    row;
   logic [1:0]    col;
   logic [XW-1:0] tx;
   logic [YW-1:0] ty;
   logic          oob_x;
   logic          oob_y;

   always_comb begin
      row = 2'd1;
      col = 2'd1;
      case (k)
         4'd0: begin row = 2'd0; col = 2'd0; end
         4'd1: begin row = 2'd0; col = 2'd1; end
         4'd2: begin row = 2'd0; col = 2'd2; end
         4'd3: begin row = 2'd1; col = 2'd0; end
         4'd4: begin row = 2'd1; col = 2'd1; end
         4'd5: begin row = 2'd1; col = 2'd2; end
         4'd6: begin row = 2'd2; col = 2'd0; end
         4'd7: begin row = 2'd2; col = 2'd1; end
         4'd8: begin row = 2'd2; col = 2'd2; end
         default: begin row = 2'd1; col = 2'd1; end
      endcase

      // Out-of-image taps replicate the nearest edge pixel.
      tx    = cx;
      oob_x = 1'b0;
      if (col == 2'd0) begin
         oob_x = (cx == '0);
         if (!oob_x) tx = cx - XW'(1);
      end else if (col == 2'd2) begin
         oob_x = (cx == XW'(WIDTH-1));
         if (!oob_x) tx = cx + XW'(1);
      end

      ty    = cy;
      oob_y = 1'b0;
      if (row == 2'd0) begin
         oob_y = (cy == '0);
         if (!oob_y) ty = cy - YW'(1);
      end else if (row == 2'd2) begin
         oob_y = (cy == YW'(HEIGHT-1));
         if (!oob_y) ty = cy + YW'(1);
      end

      addr   = AW'(ty) * AW'(WIDTH) + AW'(tx);
      weight = (k < 4'(TAP_COUNT)) ? KERNEL_WEIGHT[k] : 3'd0;
      oob    = oob_x | oob_y;
      last   = (k == 4'(TAP_COUNT-1));
   end

endmodule

// File: rtl/image_blur_full.sv
// Full-resolution 3x3 binomial blur, source BRAM to destination BRAM.
// Build option BLUR_ZERO_PAD_EN: zero-weight out-of-image taps instead of edge replication.
module image_blur_full
   import blur_pkg::*;
#(
   parameter int BIT_DEPTH = 8,
   parameter int WIDTH     = 64,
   parameter int HEIGHT    = 64
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   output logic [$clog2(WIDTH*HEIGHT)-1:0] ext_read_addr,
   output logic                            ext_read_addr_valid,
   input  logic [BIT_DEPTH-1:0]            ext_pixel_in,
   output logic [$clog2(WIDTH*HEIGHT)-1:0] ext_write_addr,
   output logic                            ext_write_valid,
   output logic [BIT_DEPTH-1:0]            ext_pixel_out,
   input  logic                            start_in,
   output logic                            blur_done,
   output logic                            busy_out,
   output logic [$clog2(WIDTH)-1:0]        out_x_used,
   output logic [$clog2(HEIGHT)-1:0]       out_y_used
);

   // state | meaning
   // IDLE  | waiting for start_in
   // ISSUE | one tap read per cycle, raster order over all centres
   // DRAIN | last read issued, waiting for the final write

   localparam int XW    = $clog2(WIDTH);
   localparam int YW    = $clog2(HEIGHT);
   localparam int AW    = $clog2(WIDTH*HEIGHT);
   localparam int ACC_W = BIT_DEPTH + 4;

`ifdef BLUR_ZERO_PAD_EN
   localparam bit ZERO_PAD = 1'b1;
`else
   localparam bit ZERO_PAD = 1'b0;
`endif

   blur_state_t state, state_nxt;

   logic [XW-1:0]    cx;
   logic [YW-1:0]    cy;
   logic [3:0]       k;
   logic [AW-1:0]    tap_addr;
   logic [2:0]       tap_w_raw;
   logic [2:0]       tap_w;
   logic             tap_oob;
   logic             tap_last;
   logic             issue;
   logic             issue_final;

   logic             s1_valid, s1_first, s1_last, s1_final;
   logic [2:0]       s1_w;
   logic [XW-1:0]    s1_cx;
   logic [YW-1:0]    s1_cy;
   logic             s2_valid, s2_first, s2_last, s2_final;
   logic [2:0]       s2_w;
   logic [XW-1:0]    s2_cx;
   logic [YW-1:0]    s2_cy;

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] prod;
   logic [ACC_W-1:0] sum;
   logic [ACC_W-1:0] rounded;

   blur_tap_addr_gen #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_tap_gen (
      .cx     (cx),
      .cy     (cy),
      .k      (k),
      .addr   (tap_addr),
      .weight (tap_w_raw),
      .oob    (tap_oob),
      .last   (tap_last)
   );

   // Zero-pad still reads the clamped address so issue timing never changes.
   assign tap_w       = (ZERO_PAD && tap_oob) ? 3'd0 : tap_w_raw;
   assign issue       = (state == ISSUE);
   assign issue_final = issue && tap_last && (cx == XW'(WIDTH-1)) && (cy == YW'(HEIGHT-1));

   assign ext_read_addr       = issue ? tap_addr : '0;
   assign ext_read_addr_valid = issue;
   assign busy_out            = (state != IDLE);

   assign prod    = ACC_W'(s2_w) * ACC_W'(ext_pixel_in);
   assign sum     = s2_first ? prod : (acc + prod);
   assign rounded = sum + ACC_W'(ROUND_BIAS);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_in)    state_nxt = ISSUE;
         ISSUE:   if (issue_final) state_nxt = DRAIN;
         DRAIN:   if (blur_done)   state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state           <= IDLE;
         cx              <= '0;
         cy              <= '0;
         k               <= '0;
         s1_valid        <= 1'b0;
         s1_first        <= 1'b0;
         s1_last         <= 1'b0;
         s1_final        <= 1'b0;
         s1_w            <= '0;
         s1_cx           <= '0;
         s1_cy           <= '0;
         s2_valid        <= 1'b0;
         s2_first        <= 1'b0;
         s2_last         <= 1'b0;
         s2_final        <= 1'b0;
         s2_w            <= '0;
         s2_cx           <= '0;
         s2_cy           <= '0;
         acc             <= '0;
         ext_pixel_out   <= '0;
         ext_write_addr  <= '0;
         ext_write_valid <= 1'b0;
         blur_done       <= 1'b0;
         out_x_used      <= '0;
         out_y_used      <= '0;
      end else begin
         state <= state_nxt;

         if (issue) begin
            if (tap_last) begin
               k <= '0;
               if (cx == XW'(WIDTH-1)) begin
                  cx <= '0;
                  cy <= (cy == YW'(HEIGHT-1)) ? '0 : cy + YW'(1);
               end else begin
                  cx <= cx + XW'(1);
               end
            end else begin
               k <= k + 4'd1;
            end
         end

         // Two-stage tap pipe lines weight and flags up with BRAM read latency.
         s1_valid <= issue;
         s1_first <= issue && (k == 4'd0);
         s1_last  <= issue && tap_last;
         s1_final <= issue_final;
         s1_w     <= tap_w;
         s1_cx    <= cx;
         s1_cy    <= cy;

         s2_valid <= s1_valid;
         s2_first <= s1_first;
         s2_last  <= s1_last;
         s2_final <= s1_final;
         s2_w     <= s1_w;
         s2_cx    <= s1_cx;
         s2_cy    <= s1_cy;

         ext_write_valid <= 1'b0;
         blur_done       <= 1'b0;
         if (s2_valid) begin
            acc <= sum;
            if (s2_last) begin
               ext_pixel_out   <= BIT_DEPTH'(rounded >> KERNEL_SHIFT);
               ext_write_addr  <= AW'(s2_cy) * AW'(WIDTH) + AW'(s2_cx);
               ext_write_valid <= 1'b1;
               out_x_used      <= s2_cx;
               out_y_used      <= s2_cy;
               blur_done       <= s2_final;
            end
         end
      end
   end

endmodule

// File: tb/tb_image_blur_full.sv
// Scoreboard bench for image_blur_full on an 8x8 image; honours BLUR_ZERO_PAD_EN.
module tb_image_blur_full;

   localparam int BD = 8;
   localparam int W  = 8;
   localparam int H  = 8;
   localparam int N  = W*H;
   localparam int AW = $clog2(N);
   localparam int PASS_CYC = 9*N + 3;

`ifdef BLUR_ZERO_PAD_EN
   localparam bit ZP = 1'b1;
`else
   localparam bit ZP = 1'b0;
`endif

   typedef struct {
      int addr;
      int pix;
   } wr_t;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          start_in;
   logic [AW-1:0] ext_read_addr;
   logic          ext_read_addr_valid;
   logic [BD-1:0] ext_pixel_in;
   logic [AW-1:0] ext_write_addr;
   logic          ext_write_valid;
   logic [BD-1:0] ext_pixel_out;
   logic          blur_done;
   logic          busy_out;
   logic [2:0]    out_x_used;
   logic [2:0]    out_y_used;

   int  img     [N];
   int  out_img [N];
   int  rd_q[$];
   wr_t wr_q[$];
   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   int  rd_count, wr_count, first_rd;
   logic [BD-1:0] d1;

   always #5 clk_in = ~clk_in;

   image_blur_full #(.BIT_DEPTH(BD), .WIDTH(W), .HEIGHT(H)) dut (
      .clk_in              (clk_in),
      .rst_in              (rst_in),
      .ext_read_addr       (ext_read_addr),
      .ext_read_addr_valid (ext_read_addr_valid),
      .ext_pixel_in        (ext_pixel_in),
      .ext_write_addr      (ext_write_addr),
      .ext_write_valid     (ext_write_valid),
      .ext_pixel_out       (ext_pixel_out),
      .start_in            (start_in),
      .blur_done           (blur_done),
      .busy_out            (busy_out),
      .out_x_used          (out_x_used),
      .out_y_used          (out_y_used)
   );

   // Source BRAM with two cycles of read latency.
   always @(posedge clk_in) begin
      d1           <= BD'(img[ext_read_addr]);
      ext_pixel_in <= d1;
      cyc          <= cyc + 1;
   end

   always @(negedge clk_in) begin
      int  ea;
      wr_t ew;
      if (ext_read_addr_valid) begin
         rd_count++;
         if (first_rd < 0) first_rd = cyc;
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL read_unexpected: addr %0d at cycle %0d, no read expected", ext_read_addr, cyc);
         end else begin
            ea = rd_q.pop_front();
            if (int'(ext_read_addr) !== ea) begin
               errors++;
               $display("FAIL read_addr: got %0d expected %0d at cycle %0d", ext_read_addr, ea, cyc);
            end
         end
      end
      if (ext_write_valid) begin
         wr_count++;
         out_img[ext_write_addr] = int'(ext_pixel_out);
         checks++;
         if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: addr %0d pix %0d, no write expected", ext_write_addr, ext_pixel_out);
         end else begin
            ew = wr_q.pop_front();
            if (int'(ext_write_addr) !== ew.addr || int'(ext_pixel_out) !== ew.pix ||
                int'(out_x_used) !== ew.addr % W || int'(out_y_used) !== ew.addr / W) begin
               errors++;
               $display("FAIL write: got addr %0d pix %0d x %0d y %0d expected addr %0d pix %0d",
                        ext_write_addr, ext_pixel_out, out_x_used, out_y_used, ew.addr, ew.pix);
            end
         end
         if (blur_done) begin
            checks++;
            if (int'(ext_write_addr) !== N-1) begin
               errors++;
               $display("FAIL done_addr: blur_done with write addr %0d expected %0d", ext_write_addr, N-1);
            end
         end
      end else if (blur_done) begin
         checks++;
         errors++;
         $display("FAIL done_no_write: blur_done without ext_write_valid at cycle %0d", cyc);
      end
   end

   function automatic int golden(int x, int y);
      int s, tx, ty, w;
      s = 0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            tx = x + dx;
            ty = y + dy;
            w  = (2 - (dx < 0 ? -dx : dx)) * (2 - (dy < 0 ? -dy : dy));
            if (tx < 0 || tx >= W || ty < 0 || ty >= H) begin
               if (ZP) w = 0;
               tx = (tx < 0) ? 0 : (tx >= W) ? W-1 : tx;
               ty = (ty < 0) ? 0 : (ty >= H) ? H-1 : ty;
            end
            s += w * img[ty*W + tx];
         end
      end
      return (s + 8) / 16;
   endfunction

   task automatic push_expected();
      wr_t e;
      int  tx, ty;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  tx = x + dx;
                  ty = y + dy;
                  tx = (tx < 0) ? 0 : (tx >= W) ? W-1 : tx;
                  ty = (ty < 0) ? 0 : (ty >= H) ? H-1 : ty;
                  rd_q.push_back(ty*W + tx);
               end
            end
            e.addr = y*W + x;
            e.pix  = golden(x, y);
            wr_q.push_back(e);
         end
      end
   endtask

   task automatic load_const(input int v);
      for (int i = 0; i < N; i++) img[i] = v;
   endtask

   task automatic clear_stats();
      rd_count = 0;
      wr_count = 0;
      first_rd = -1;
      for (int i = 0; i < N; i++) out_img[i] = -1;
   endtask

   task automatic pulse_start(output int t0);
      @(negedge clk_in);
      start_in = 1'b1;
      t0 = cyc;
      @(negedge clk_in);
      start_in = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int dcyc);
      dcyc = -1;
      for (int i = 0; i < limit; i++) begin
         if (blur_done === 1'b1) begin
            dcyc = cyc;
            break;
         end
         @(negedge clk_in);
      end
   endtask

   task automatic test_reset();
      rst_in   = 1'b1;
      start_in = 1'b0;
      repeat (3) @(negedge clk_in);
      checks++;
      if (ext_read_addr_valid !== 1'b0 || ext_read_addr !== '0 || ext_write_valid !== 1'b0 ||
          ext_write_addr !== '0 || ext_pixel_out !== '0 || blur_done !== 1'b0 ||
          busy_out !== 1'b0 || out_x_used !== '0 || out_y_used !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rv %0b ra %0d wv %0b wa %0d pix %0d done %0b busy %0b x %0d y %0d, all required 0",
                  ext_read_addr_valid, ext_read_addr, ext_write_valid, ext_write_addr, ext_pixel_out,
                  blur_done, busy_out, out_x_used, out_y_used);
      end
      rst_in = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_constant();
      int t0, d, nbad;
      load_const(100);
      clear_stats();
      push_expected();
      pulse_start(t0);
      checks++;
      if (busy_out !== 1'b1 || ext_read_addr_valid !== 1'b1) begin
         errors++;
         $display("FAIL const_busy_rise: busy %0b rvalid %0b at T+1, required 1 1", busy_out, ext_read_addr_valid);
      end
      wait_done(PASS_CYC + 20, d);
      checks++;
      if (d !== t0 + PASS_CYC) begin
         errors++;
         $display("FAIL const_done_cycle: got %0d required %0d", d, t0 + PASS_CYC);
      end
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      checks++;
      if (busy_out !== 1'b0 || ext_read_addr_valid !== 1'b0) begin
         errors++;
         $display("FAIL const_busy_fall: busy %0b rvalid %0b after done, required 0 0", busy_out, ext_read_addr_valid);
      end
      repeat (5) @(negedge clk_in);
      checks++;
      if (busy_out !== 1'b0) begin
         errors++;
         $display("FAIL start_at_done: busy %0b after start coincident with done, required 0", busy_out);
      end
      checks++;
      if (first_rd !== t0 + 1 || rd_count !== 9*N || wr_count !== N || wr_q.size() !== 0) begin
         errors++;
         $display("FAIL const_counts: first_rd %0d reads %0d writes %0d left %0d, required %0d %0d %0d 0",
                  first_rd, rd_count, wr_count, wr_q.size(), t0 + 1, 9*N, N);
      end
      nbad = 0;
`ifdef BLUR_ZERO_PAD_EN
      for (int y = 1; y < H-1; y++)
         for (int x = 1; x < W-1; x++)
            if (out_img[y*W+x] !== 100) nbad++;
`else
      for (int i = 0; i < N; i++)
         if (out_img[i] !== 100) nbad++;
`endif
      checks++;
      if (nbad !== 0) begin
         errors++;
         $display("FAIL const_values: %0d pixels differ from required 100", nbad);
      end
   endtask

   task automatic test_impulse_center();
      int t0, d, nbad;
      int sx [9] = '{3, 2, 4, 3, 3, 2, 4, 2, 4};
      int sy [9] = '{3, 3, 3, 2, 4, 2, 2, 4, 4};
      int sv [9] = '{40, 20, 20, 20, 20, 10, 10, 10, 10};
      load_const(0);
      img[3*W+3] = 160;
      clear_stats();
      push_expected();
      pulse_start(t0);
      wait_done(PASS_CYC + 20, d);
      checks++;
      if (d !== t0 + PASS_CYC) begin
         errors++;
         $display("FAIL center_done_cycle: got %0d required %0d", d, t0 + PASS_CYC);
      end
      repeat (3) @(negedge clk_in);
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (out_img[sy[i]*W+sx[i]] !== sv[i]) begin
            errors++;
            $display("FAIL center_spot(%0d,%0d): got %0d required %0d", sx[i], sy[i], out_img[sy[i]*W+sx[i]], sv[i]);
         end
      end
      nbad = 0;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            if ((x < 2 || x > 4 || y < 2 || y > 4) && out_img[y*W+x] !== 0) nbad++;
      checks++;
      if (nbad !== 0) begin
         errors++;
         $display("FAIL center_zero: %0d far pixels nonzero, required 0", nbad);
      end
   endtask

   task automatic test_impulse_corner();
      int t0, d;
`ifdef BLUR_ZERO_PAD_EN
      int ev [3] = '{40, 20, 10};
`else
      int ev [3] = '{90, 30, 10};
`endif
      int ea [3] = '{0, 1, W+1};
      load_const(0);
      img[0] = 160;
      clear_stats();
      push_expected();
      pulse_start(t0);
      wait_done(PASS_CYC + 20, d);
      repeat (3) @(negedge clk_in);
      checks++;
      if (d !== t0 + PASS_CYC || first_rd !== t0 + 1 || rd_count !== 9*N) begin
         errors++;
         $display("FAIL corner_timing: done %0d first_rd %0d reads %0d, required %0d %0d %0d",
                  d, first_rd, rd_count, t0 + PASS_CYC, t0 + 1, 9*N);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_img[ea[i]] !== ev[i]) begin
            errors++;
            $display("FAIL corner_spot addr %0d: got %0d required %0d", ea[i], out_img[ea[i]], ev[i]);
         end
      end
   endtask

   task automatic test_handshake();
      int t0, d, seen;
      for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
      clear_stats();
      push_expected();
      pulse_start(t0);
      while (cyc < t0 + 100) @(negedge clk_in);
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      while (cyc < t0 + 200) @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      rd_q.delete();
      wr_q.delete();
      checks++;
      if (ext_read_addr_valid !== 1'b0 || ext_read_addr !== '0 || ext_write_valid !== 1'b0 ||
          ext_write_addr !== '0 || ext_pixel_out !== '0 || blur_done !== 1'b0 ||
          busy_out !== 1'b0 || out_x_used !== '0 || out_y_used !== '0) begin
         errors++;
         $display("FAIL abort_outputs: rv %0b ra %0d wv %0b wa %0d pix %0d done %0b busy %0b, all required 0",
                  ext_read_addr_valid, ext_read_addr, ext_write_valid, ext_write_addr, ext_pixel_out,
                  blur_done, busy_out);
      end
      checks++;
      if (rd_count !== 200) begin
         errors++;
         $display("FAIL abort_reads: %0d reads before reset, required 200", rd_count);
      end
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_in);
         if (blur_done || ext_write_valid || busy_out) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abort_quiet: %0d active cycles after reset, required 0", seen);
      end
      clear_stats();
      push_expected();
      pulse_start(t0);
      wait_done(PASS_CYC + 20, d);
      repeat (3) @(negedge clk_in);
      checks++;
      if (d !== t0 + PASS_CYC || wr_count !== N || wr_q.size() !== 0) begin
         errors++;
         $display("FAIL restart_pass: done %0d writes %0d left %0d, required %0d %0d 0",
                  d, wr_count, wr_q.size(), t0 + PASS_CYC, N);
      end
   endtask

   task automatic test_saturate();
      int t0, d, nbad;
      load_const(255);
      clear_stats();
      push_expected();
      pulse_start(t0);
      wait_done(PASS_CYC + 20, d);
      repeat (3) @(negedge clk_in);
      checks++;
      if (d !== t0 + PASS_CYC) begin
         errors++;
         $display("FAIL sat_done_cycle: got %0d required %0d", d, t0 + PASS_CYC);
      end
      nbad = 0;
`ifdef BLUR_ZERO_PAD_EN
      for (int y = 1; y < H-1; y++)
         for (int x = 1; x < W-1; x++)
            if (out_img[y*W+x] !== 255) nbad++;
`else
      for (int i = 0; i < N; i++)
         if (out_img[i] !== 255) nbad++;
`endif
      checks++;
      if (nbad !== 0) begin
         errors++;
         $display("FAIL sat_values: %0d pixels differ from required 255", nbad);
      end
   endtask

   initial begin
      rst_in   = 1'b1;
      start_in = 1'b0;
      load_const(0);
      clear_stats();
      test_reset();
      test_constant();
      test_impulse_center();
      test_impulse_corner();
      test_handshake();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
